// File: rtl/drink_dispense_ctrl.sv
// rtl/drink_dispense_ctrl.sv - vend command queue and timed drink/change actuator sequencer
//
// Purpose: queues vend commands (Z = 10 drink, 11 drink + change) from the coin
// FSM and plays each one out as timed actuator pulses: drink motor, drop-sensor
// confirmation, then coin ejector when change is owed.
// Optional build macro: DISPENSE_STATS_EN adds the Drink_cnt / Change_cnt outputs.
//
// Ports:
//   CP_20ms       in   clock, 20 ms period
//   Rst_sync      in   synchronous reset, active-high
//   Z[1:0]        in   vend command (00 none, 10 drink, 11 drink+change, 01 ignored)
//   Drink_sensor  in   drop sensor, high >= 1 cycle per dropped drink
//   Fault_clr     in   single-cycle pulse, leaves FAULT
//   Drink_motor   out  drink motor enable
//   Coin_out      out  change ejector enable
//   Busy          out  sequencer not idle
//   Pending       out  queued commands, excluding the one executing
//   Overflow      out  sticky, a command was dropped on a full queue
//   Fault         out  sequencer in FAULT
//   Drink_cnt     out  (DISPENSE_STATS_EN) sensor-confirmed drinks, saturating
//   Change_cnt    out  (DISPENSE_STATS_EN) completed change ejections, saturating

module drink_dispense_ctrl #(
   parameter int FIFO_DEPTH    = 4,
   parameter int DRINK_TICKS   = 25,
   parameter int SENSE_TIMEOUT = 100,
   parameter int COIN_TICKS    = 10,
   parameter int GAP_TICKS     = 5
) (
   input  logic                          CP_20ms,
   input  logic                          Rst_sync,
   input  logic [1:0]                    Z,
   input  logic                          Drink_sensor,
   input  logic                          Fault_clr,
   output logic                          Drink_motor,
   output logic                          Coin_out,
   output logic                          Busy,
   output logic [$clog2(FIFO_DEPTH):0]   Pending,
   output logic                          Overflow,
   output logic                          Fault
`ifdef DISPENSE_STATS_EN
   ,
   output logic [15:0]                   Drink_cnt,
   output logic [15:0]                   Change_cnt
`endif
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int MAX_A = (DRINK_TICKS > SENSE_TIMEOUT) ? DRINK_TICKS : SENSE_TIMEOUT;
   localparam int MAX_B = (COIN_TICKS > GAP_TICKS) ? COIN_TICKS : GAP_TICKS;
   localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_T + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRINK_ON,
      S_DRINK_WAIT,
      S_CHANGE_ON,
      S_GAP,
      S_FAULT
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CW-1:0]       r_tick;
   logic [CW-1:0]       w_reload;
   logic [CW-1:0]       w_tick_next;
   logic [1:0]          r_z_prev;
   logic [FIFO_DEPTH-1:0] r_fifo;
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW:0]         r_count;
   logic                r_change;
   logic                r_sensed;
   logic                r_motor;
   logic                r_coin;
   logic                r_busy;
   logic                r_fault;
   logic                r_overflow;
   logic                w_strobe;
   logic                w_full;
   logic                w_deq;
   logic                w_enq;
   logic                w_sense;
   logic                w_confirm;
   logic                w_coin_done;

   // A held Z enqueues once: only a change onto a vend code counts.
   assign w_strobe = ((Z == 2'b10) || (Z == 2'b11)) && (Z != r_z_prev);
   assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
   // A full queue still accepts when the sequencer pops in the same cycle.
   assign w_enq    = w_strobe && (!w_full || w_deq);
   // A drop seen while the motor was still running counts as confirmation.
   assign w_sense  = r_sensed || Drink_sensor;

   always_comb begin
      w_next      = r_state;
      w_deq       = 1'b0;
      w_confirm   = 1'b0;
      w_coin_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_deq  = 1'b1;
               w_next = S_DRINK_ON;
            end
         end
         S_DRINK_ON: begin
            if (r_tick == '0) w_next = S_DRINK_WAIT;
         end
         S_DRINK_WAIT: begin
            if (w_sense) begin
               w_confirm = 1'b1;
               w_next    = r_change ? S_CHANGE_ON : S_GAP;
            end else if (r_tick == '0) begin
               w_next = S_FAULT;
            end
         end
         S_CHANGE_ON: begin
            if (r_tick == '0) begin
               w_coin_done = 1'b1;
               w_next      = S_GAP;
            end
         end
         S_GAP: begin
            if (r_tick == '0) w_next = S_IDLE;
         end
         S_FAULT: begin
            if (Fault_clr) w_next = S_GAP;
         end
         default: w_next = S_IDLE;
      endcase

      // Shared down-counter: loaded with (duration - 1) on every state entry.
      case (w_next)
         S_DRINK_ON:   w_reload = CW'(DRINK_TICKS - 1);
         S_DRINK_WAIT: w_reload = CW'(SENSE_TIMEOUT - 1);
         S_CHANGE_ON:  w_reload = CW'(COIN_TICKS - 1);
         S_GAP:        w_reload = CW'(GAP_TICKS - 1);
         default:      w_reload = '0;
      endcase

      if (w_next != r_state)   w_tick_next = w_reload;
      else if (r_tick != '0)   w_tick_next = r_tick - CW'(1);
      else                     w_tick_next = r_tick;
   end

   always_ff @(posedge CP_20ms) begin
      if (Rst_sync) begin
         r_state    <= S_IDLE;
         r_tick     <= '0;
         r_z_prev   <= 2'b00;
         r_fifo     <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_change   <= 1'b0;
         r_sensed   <= 1'b0;
         r_motor    <= 1'b0;
         r_coin     <= 1'b0;
         r_busy     <= 1'b0;
         r_fault    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_tick   <= w_tick_next;
         r_z_prev <= Z;

         if (w_enq) begin
            r_fifo[r_wr_ptr] <= Z[0];
            r_wr_ptr         <= r_wr_ptr + AW'(1);
         end
         if (w_deq) begin
            r_change <= r_fifo[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_strobe && !w_enq) r_overflow <= 1'b1;

         if (w_next == S_DRINK_ON && r_state != S_DRINK_ON)
            r_sensed <= 1'b0;
         else if (r_state == S_DRINK_ON && Drink_sensor)
            r_sensed <= 1'b1;

         // Outputs follow the next state so they line up with it exactly.
         r_motor <= (w_next == S_DRINK_ON);
         r_coin  <= (w_next == S_CHANGE_ON);
         r_busy  <= (w_next != S_IDLE);
         r_fault <= (w_next == S_FAULT);
      end
   end

   assign Drink_motor = r_motor;
   assign Coin_out    = r_coin;
   assign Busy        = r_busy;
   assign Pending     = r_count;
   assign Overflow    = r_overflow;
   assign Fault       = r_fault;

`ifdef DISPENSE_STATS_EN
   logic [15:0] r_drink_cnt;
   logic [15:0] r_change_cnt;

   always_ff @(posedge CP_20ms) begin
      if (Rst_sync) begin
         r_drink_cnt  <= '0;
         r_change_cnt <= '0;
      end else begin
         if (w_confirm && r_drink_cnt != 16'hFFFF)
            r_drink_cnt <= r_drink_cnt + 16'd1;
         if (w_coin_done && r_change_cnt != 16'hFFFF)
            r_change_cnt <= r_change_cnt + 16'd1;
      end
   end

   assign Drink_cnt  = r_drink_cnt;
   assign Change_cnt = r_change_cnt;
`endif

endmodule

// File: tb/tb_drink_dispense_ctrl.sv
// tb/tb_drink_dispense_ctrl.sv - self-checking bench for drink_dispense_ctrl

module tb_drink_dispense_ctrl;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       Rst_sync;
   logic [1:0] Z;
   logic       Fault_clr;
   logic       sens_man;
   logic       sens_auto;
   logic       Drink_sensor;
   logic       Drink_motor;
   logic       Coin_out;
   logic       Busy;
   logic [2:0] Pending;
   logic       Overflow;
   logic       Fault;
`ifdef DISPENSE_STATS_EN
   logic [15:0] Drink_cnt;
   logic [15:0] Change_cnt;
`endif

   assign Drink_sensor = sens_man | sens_auto;

   always #5 clk = ~clk;

   drink_dispense_ctrl dut (
      .CP_20ms      (clk),
      .Rst_sync     (Rst_sync),
      .Z            (Z),
      .Drink_sensor (Drink_sensor),
      .Fault_clr    (Fault_clr),
      .Drink_motor  (Drink_motor),
      .Coin_out     (Coin_out),
      .Busy         (Busy),
      .Pending      (Pending),
      .Overflow     (Overflow),
      .Fault        (Fault)
`ifdef DISPENSE_STATS_EN
      ,
      .Drink_cnt    (Drink_cnt),
      .Change_cnt   (Change_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: per-job timeline ----------------
   // A job started (dequeued) at edge s: motor on edges s..s+24; the drop is
   // confirmed at c = max(first sensor edge > s, s+26); no sensor by edge s+125
   // means fault. After c: change -> coin on c..c+9, idle at c+15; else idle c+5.
   // After a fault cleared at edge k: idle at k+5.
   bit   q[$];
   int   n = 0;
   bit [1:0] m_zp;
   bit   m_ovf, act, chg;
   int   s, fs, c, fe, ce, ee;
   int   m_dc, m_cc;
   bit   m_motor, m_coin, m_busy, m_fault;
   int   m_pend;
   bit   chk_en = 0;

   always @(posedge clk) begin
      bit strobe;
      n++;
      if (Rst_sync) begin
         chk_en = 1;
         q.delete();
         m_zp = 2'b00; m_ovf = 0; act = 0; chg = 0;
         m_dc = 0; m_cc = 0;
         m_motor = 0; m_coin = 0; m_busy = 0; m_fault = 0; m_pend = 0;
      end else begin
         strobe = ((Z == 2'b10) || (Z == 2'b11)) && (Z != m_zp);
         if (!act && q.size() > 0) begin
            chg = q.pop_front();
            act = 1; s = n; fs = -1; c = -1; fe = -1; ce = -1; ee = -1;
         end else if (act) begin
            if (c < 0 && fe < 0) begin
               if (fs < 0 && Drink_sensor) fs = n;
               if (fs >= 0 && n >= s + 26) begin
                  c = n; ee = chg ? c + 15 : c + 5; m_dc++;
               end else if (n == s + 125) begin
                  fe = n;
               end
            end else if (fe >= 0 && ce < 0 && n > fe && Fault_clr) begin
               ce = n; ee = n + 5;
            end
            if (chg && c >= 0 && n == c + 10) m_cc++;
         end
         if (strobe) begin
            if (q.size() < DEPTH) q.push_back(Z[0]);
            else m_ovf = 1;
         end
         m_zp    = Z;
         m_motor = act && n >= s && n <= s + 24;
         m_coin  = act && chg && c >= 0 && n >= c && n <= c + 9;
         m_fault = act && fe >= 0 && n >= fe && ce < 0;
         m_busy  = act && !(ee >= 0 && n >= ee);
         if (act && ee >= 0 && n >= ee) act = 0;
         m_pend  = q.size();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("Drink_motor", Drink_motor, m_motor);
         chk("Coin_out", Coin_out, m_coin);
         chk("Busy", Busy, m_busy);
         chk("Fault", Fault, m_fault);
         chk("Pending", Pending, m_pend);
         chk("Overflow", Overflow, m_ovf);
         chk("actuator_exclusive", Drink_motor & Coin_out, 0);
`ifdef DISPENSE_STATS_EN
         chk("Drink_cnt", Drink_cnt, m_dc);
         chk("Change_cnt", Change_cnt, m_cc);
`endif
      end
   end

   // ---------------- measurement and automatic drop-sensor responder ----------------
   int meas_motor = 0, meas_coin = 0, meas_rise = 0;
   bit prev_m = 0;
   bit auto_en = 0;
   int auto_dly = 2;
   int resp_cnt = 0;

   always @(negedge clk) begin
      meas_motor += Drink_motor;
      meas_coin  += Coin_out;
      if (Drink_motor && !prev_m) meas_rise++;
      sens_auto = 0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) sens_auto = 1;
      end
      if (prev_m && !Drink_motor && auto_en) resp_cnt = auto_dly + 1;
      prev_m = Drink_motor;
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wait_idle(input string nm, input int lim);
      int k = 0;
      while (!(Busy == 0 && Pending == 0) && k < lim) begin cyc(1); k++; end
      chk({"timeout_idle_", nm}, (Busy == 0 && Pending == 0), 1);
   endtask

   task automatic wait_motor(input string nm, input int lim);
      int k = 0;
      while (Drink_motor !== 1'b1 && k < lim) begin cyc(1); k++; end
      chk({"timeout_motor_", nm}, Drink_motor, 1);
   endtask

   task automatic strobe_once(input logic [1:0] v);
      Z = v; cyc(1); Z = 2'b00;
   endtask

   initial begin
      int m0, c0, r0, peak;
      Rst_sync = 1; Z = 2'b00; Fault_clr = 0; sens_man = 0; sens_auto = 0;
      cyc(3);
      chk("reset_motor", Drink_motor, 0);
      chk("reset_coin", Coin_out, 0);
      chk("reset_busy", Busy, 0);
      chk("reset_pending", Pending, 0);
      chk("reset_overflow", Overflow, 0);
      chk("reset_fault", Fault, 0);
      Rst_sync = 0;
      cyc(2);

      // drink only, sensor 3 cycles after motor off
      auto_en = 1; auto_dly = 2;
      m0 = meas_motor; c0 = meas_coin;
      strobe_once(2'b10);
      wait_idle("t1", 200);
      chk("t1_motor_cycles", meas_motor - m0, 25);
      chk("t1_coin_cycles", meas_coin - c0, 0);

      // drink + change held 4 cycles -> single enqueue
      m0 = meas_motor; c0 = meas_coin; peak = 0;
      Z = 2'b11;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         if (Pending > peak) peak = Pending;
      end
      Z = 2'b00;
      wait_idle("t2", 200);
      chk("t2_pending_peak", peak, 1);
      chk("t2_motor_cycles", meas_motor - m0, 25);
      chk("t2_coin_cycles", meas_coin - c0, 10);

      // no sensor -> fault; queue during fault; clear and dispense queued drink
      auto_en = 0;
      m0 = meas_motor;
      strobe_once(2'b10);
      begin
         int k = 0;
         while (Fault !== 1'b1 && k < 200) begin cyc(1); k++; end
         chk("t3_timeout_fault", Fault, 1);
      end
      chk("t3_fault_motor", Drink_motor, 0);
      strobe_once(2'b10);
      chk("t3_pending_in_fault", Pending, 1);
      cyc(3);
      auto_en = 1;
      Fault_clr = 1; cyc(1); Fault_clr = 0;
      chk("t3_fault_cleared", Fault, 0);
      wait_idle("t3", 300);
      chk("t3_motor_cycles", meas_motor - m0, 50);

      // 6 strobes during a dispense -> 4 queued, overflow, 5 drinks total
      r0 = meas_rise;
      strobe_once(2'b10);
      wait_motor("t4", 20);
      for (int i = 0; i < 6; i++) begin
         Z = 2'b10; cyc(1); Z = 2'b00; cyc(1);
      end
      chk("t4_pending_full", Pending, 4);
      chk("t4_overflow", Overflow, 1);
      wait_idle("t4", 600);
      chk("t4_drinks", meas_rise - r0, 5);

      // reset at cycle 10 of DRINK_ON with a command queued
      strobe_once(2'b10);
      wait_motor("t5", 20);
      Z = 2'b10; cyc(1); Z = 2'b00; cyc(1);
      cyc(7);
      Rst_sync = 1; cyc(1); Rst_sync = 0;
      chk("t5_motor", Drink_motor, 0);
      chk("t5_pending", Pending, 0);
      chk("t5_busy", Busy, 0);
      chk("t5_overflow", Overflow, 0);

      // illegal 01 ignored
      Z = 2'b01; cyc(3); Z = 2'b00; cyc(1);
      chk("t6_pending", Pending, 0);
      chk("t6_busy", Busy, 0);

      // 2 drink-only + 1 drink+change
      strobe_once(2'b10); cyc(1);
      strobe_once(2'b10); cyc(1);
      strobe_once(2'b11);
      wait_idle("t7", 600);
`ifdef DISPENSE_STATS_EN
      chk("t7_drink_cnt", Drink_cnt, 3);
      chk("t7_change_cnt", Change_cnt, 1);
`endif

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 10)      Z = 2'b10;
         else if (r < 18) Z = 2'b11;
         else if (r < 21) Z = 2'b01;
         else if (r < 40) Z = 2'b00;
         Fault_clr = ($urandom_range(0, 29) == 0);
         sens_man  = ($urandom_range(0, 39) == 0);
         auto_dly  = $urandom_range(0, 30);
         if (i % 200 == 0) auto_en = ($urandom_range(0, 9) != 0);
         Rst_sync  = ($urandom_range(0, 699) == 0);
         cyc(1);
      end
      Z = 2'b00; Fault_clr = 0; sens_man = 0; Rst_sync = 0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
